trace_dumper: RTL and testbench

Drains the sigma_tile memory-access trace buffer after a capture run. On command it freezes capture, reads every buffered record oldest-first through the tracer's external read port, and serializes each record into a byte stream for a UART/debug transmitter. When the dump is complete it flushes the buffer. It sits directly downstream of mem_tracer: it drives that block's trace control bits and is the master on its external MemSplit32 read port.

---
 rtl/trace_dumper_pkg.sv | 30 +++
 rtl/mem_split32.sv | 12 +
 rtl/trace_rec_ser.sv | 55 +++++
 rtl/trace_dumper.sv | 167 ++++++++++++++++
 tb/tb_trace_dumper.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_dumper_pkg.sv
// Shared constants, FSM state type and record packing helper for the trace
// dump path that drains mem_tracer into a byte stream.
package trace_dumper_pkg;

    localparam int TRACE_EN_BIT    = 0;
    localparam int TRACE_FLUSH_BIT = 1;

    localparam logic [1:0] TRACE_FLD_ADDR = 2'd0;
    localparam logic [1:0] TRACE_FLD_DATA = 2'd1;
    localparam logic [1:0] TRACE_FLD_WE   = 2'd2;

    localparam int TRACE_REC_BYTES = 9;
    localparam int TRACE_REC_WIDTH = 65;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        SEND    = 3'd3,
        FLUSH   = 3'd4,
        DONE    = 3'd5
    } trace_dump_state_t;

    function automatic logic [TRACE_REC_WIDTH-1:0] rec_pack(input logic flag,
                                                            input logic [31:0] data,
                                                            input logic [31:0] addr);
        return {flag, data, addr};
    endfunction

endpackage

// File: rtl/mem_split32.sv
// Split-transaction 32-bit memory port: request/ack handshake, response later.
interface MemSplit32;
    logic        req;
    logic        ack;
    logic        we;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        resp;

    modport master (output req, we, addr, input ack, rdata, resp);
    modport slave  (input req, we, addr, output ack, rdata, resp);
endinterface

// File: rtl/trace_rec_ser.sv
// Serializes one 65-bit trace record {flag, data, addr} into nine bytes,
// least-significant byte first, over a registered valid/ready stream.
module trace_rec_ser
    import trace_dumper_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [TRACE_REC_WIDTH-1:0] rec,
    input  logic                       ready,
    output logic                       valid,
    output logic [7:0]                 data,
    output logic                       last
);

    localparam logic [3:0] LAST_BYTE = 4'(TRACE_REC_BYTES - 1);

    // Bytes still waiting behind the one currently presented on data_r.
    logic [63:0] sr_r;
    logic [3:0]  cnt_r;
    logic        valid_r;
    logic [7:0]  data_r;

    // Byte shifter: load presents byte 0, each accepted byte presents the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r    <= 64'd0;
            cnt_r   <= 4'd0;
            valid_r <= 1'b0;
            data_r  <= 8'd0;
        end else if (load) begin
            sr_r    <= {7'd0, rec[TRACE_REC_WIDTH-1:8]};
            cnt_r   <= 4'd0;
            valid_r <= 1'b1;
            data_r  <= rec[7:0];
        end else if (valid_r && ready) begin
            if (cnt_r == LAST_BYTE) begin
                cnt_r   <= 4'd0;
                valid_r <= 1'b0;
            end else begin
                cnt_r   <= cnt_r + 4'd1;
                sr_r    <= {8'd0, sr_r[63:8]};
                data_r  <= sr_r[7:0];
            end
        end else begin
            cnt_r   <= cnt_r;
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign last  = valid_r & ready & (cnt_r == LAST_BYTE);

endmodule

// File: rtl/trace_dumper.sv
// Freezes mem_tracer capture, reads every record oldest-first over the split
// read port, streams each as nine bytes, then flushes the trace buffer.
module trace_dumper
    import trace_dumper_pkg::*;
#(
    parameter int CAPACITY = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trace_en_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [3:0]  trace_ctrl_o,
    input  logic        trace_flush_end_i,
    MemSplit32.master   trc_if,
    output logic        dout_valid_o,
    input  logic        dout_ready_i,
    output logic [7:0]  dout_data_o
);

    localparam int            AW         = $clog2(CAPACITY);
    localparam logic [AW-1:0] LAST_ENTRY = AW'(CAPACITY - 1);

    trace_dump_state_t          state_r;
    logic [AW-1:0]              entry_r;
    logic [1:0]                 field_r;
    logic [31:0]                addr_r;
    logic [31:0]                data_r;
    logic                       req_r;
    logic                       en_r;
    logic                       flush_r;
    logic                       busy_r;
    logic                       done_r;
    logic                       load_s;
    logic                       last_s;
    logic [TRACE_REC_WIDTH-1:0] rec_s;
    logic [31:0]                addr_s;
    logic [3:0]                 ctrl_s;

    // The flag word feeds the serializer straight from rdata, so the record
    // loads on the same edge that completes the third read.
    assign load_s = (state_r == RD_WAIT) && trc_if.resp && (field_r == TRACE_FLD_WE);
    assign rec_s  = rec_pack(trc_if.rdata[0], data_r, addr_r);

    // Tracer-select bit, relative entry index and field select form the read address.
    always_comb begin
        addr_s             = 32'd0;
        addr_s[AW+2]       = 1'b1;
        addr_s[AW+1:2]     = entry_r;
        addr_s[1:0]        = field_r;
    end

    // Only the enable and flush bits are ever driven toward the tracer.
    always_comb begin
        ctrl_s                  = 4'd0;
        ctrl_s[TRACE_EN_BIT]    = en_r;
        ctrl_s[TRACE_FLUSH_BIT] = flush_r;
    end

    // Dump sequencer with registered req, control bits, busy and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            entry_r <= '0;
            field_r <= TRACE_FLD_ADDR;
            addr_r  <= 32'd0;
            data_r  <= 32'd0;
            req_r   <= 1'b0;
            en_r    <= 1'b0;
            flush_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            en_r   <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        state_r <= RD_REQ;
                        entry_r <= '0;
                        field_r <= TRACE_FLD_ADDR;
                        req_r   <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        en_r    <= trace_en_i;
                    end
                end
                RD_REQ: begin
                    if (trc_if.ack) begin
                        req_r   <= 1'b0;
                        state_r <= RD_WAIT;
                    end else begin
                        req_r   <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    // resp is honoured only here; elsewhere it is stray and ignored.
                    if (trc_if.resp) begin
                        case (field_r)
                            TRACE_FLD_ADDR: addr_r <= trc_if.rdata;
                            TRACE_FLD_DATA: data_r <= trc_if.rdata;
                            default:        data_r <= data_r;
                        endcase
                        if (field_r < TRACE_FLD_WE) begin
                            field_r <= field_r + 2'd1;
                            req_r   <= 1'b1;
                            state_r <= RD_REQ;
                        end else begin
                            state_r <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (last_s) begin
                        if (entry_r == LAST_ENTRY) begin
                            flush_r <= 1'b1;
                            state_r <= FLUSH;
                        end else begin
                            entry_r <= entry_r + AW'(1);
                            field_r <= TRACE_FLD_ADDR;
                            req_r   <= 1'b1;
                            state_r <= RD_REQ;
                        end
                    end
                end
                FLUSH: begin
                    if (trace_flush_end_i) begin
                        flush_r <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    en_r    <= trace_en_i;
                    state_r <= IDLE;
                end
                default: begin
                    req_r   <= 1'b0;
                    flush_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    trace_rec_ser u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .rec   (rec_s),
        .ready (dout_ready_i),
        .valid (dout_valid_o),
        .data  (dout_data_o),
        .last  (last_s)
    );

    assign trc_if.req   = req_r;
    assign trc_if.we    = 1'b0;
    assign trc_if.addr  = addr_s;
    assign trace_ctrl_o = ctrl_s;
    assign busy_o       = busy_r;
    assign done_o       = done_r;

endmodule

// File: tb/tb_trace_dumper.sv
// Directed bench for trace_dumper with a CAPACITY=4 behavioural mem_tracer
// read port, flush counter and byte-stream collector.
module tb_trace_dumper;

    localparam int CAP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trace_en;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] trace_ctrl;
    logic       flush_end;
    logic       dout_valid;
    logic       dout_ready = 1'b1;
    logic [7:0] dout_data;

    MemSplit32 trc ();

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_dumper #(.CAPACITY(CAP)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .trace_en_i        (trace_en),
        .start_i           (start),
        .busy_o            (busy),
        .done_o            (done),
        .trace_ctrl_o      (trace_ctrl),
        .trace_flush_end_i (flush_end),
        .trc_if            (trc),
        .dout_valid_o      (dout_valid),
        .dout_ready_i      (dout_ready),
        .dout_data_o       (dout_data)
    );

    // ---------------- behavioural tracer ----------------
    logic [31:0] m_addr [CAP] = '{default: 32'd0};
    logic [31:0] m_data [CAP] = '{default: 32'd0};
    logic        m_we   [CAP] = '{default: 1'b0};
    int head = 0, wp = 0, cnt = 0, fcnt = 0, bad_addr = 0;
    logic ack_en = 1'b1, spur = 1'b0;
    logic s1_v = 1'b0, s2_v = 1'b0;
    logic [31:0] s1_d = 32'd0, s2_d = 32'd0;

    assign trc.ack   = ack_en;
    assign trc.resp  = s2_v | spur;
    assign trc.rdata = s2_v ? s2_d : 32'hDEAD_BEEF;
    assign flush_end = trace_ctrl[1] && (fcnt == CAP - 1);

    function automatic logic [31:0] lookup(input logic [31:0] a);
        int idx;
        idx = (int'(a[3:2]) + head) % CAP;
        case (a[1:0])
            2'd0:    return m_addr[idx];
            2'd1:    return m_data[idx];
            2'd2:    return {31'd0, m_we[idx]};
            default: return 32'h0BAD_0BAD;
        endcase
    endfunction

    always @(posedge clk) begin
        s1_v <= trc.req & trc.ack;
        s1_d <= lookup(trc.addr);
        s2_v <= s1_v;
        s2_d <= s1_d;
        if (trc.req && trc.ack && (trc.addr[31:5] != 27'd0 || !trc.addr[4] ||
                                   trc.addr[1:0] == 2'd3 || trc.we))
            bad_addr <= bad_addr + 1;
        if (trace_ctrl[1]) begin
            m_addr[fcnt] <= 32'd0;
            m_data[fcnt] <= 32'd0;
            m_we[fcnt]   <= 1'b0;
            if (fcnt == CAP - 1) begin
                fcnt <= 0; head <= 0; wp <= 0; cnt <= 0;
            end else begin
                fcnt <= fcnt + 1;
            end
        end
    end

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic w);
        m_addr[wp] <= a;
        m_data[wp] <= d;
        m_we[wp]   <= w;
        wp <= (wp + 1) % CAP;
        if (cnt == CAP) head <= (head + 1) % CAP;
        else            cnt  <= cnt + 1;
        @(negedge clk);
    endtask

    // ---------------- stream collector ----------------
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int   stall_err = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic bp = 1'b0;
    int   rcyc = 0;

    always @(posedge clk) begin
        if (prev_stall && (!dout_valid || dout_data != prev_data))
            stall_err <= stall_err + 1;
        prev_stall <= dout_valid & ~dout_ready;
        prev_data  <= dout_data;
        if (dout_valid && dout_ready) got_q.push_back(dout_data);
    end

    always @(negedge clk) begin
        rcyc = rcyc + 1;
        dout_ready = bp ? (rcyc % 3 == 0) : 1'b1;
    end

    task automatic add_exp(input logic [31:0] a, input logic [31:0] d, input logic w);
        exp_q.push_back(a[7:0]);  exp_q.push_back(a[15:8]);
        exp_q.push_back(a[23:16]); exp_q.push_back(a[31:24]);
        exp_q.push_back(d[7:0]);  exp_q.push_back(d[15:8]);
        exp_q.push_back(d[23:16]); exp_q.push_back(d[31:24]);
        exp_q.push_back({7'd0, w});
    endtask

    task automatic run_dump(input int budget, output int dcyc);
        dcyc = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (trace_ctrl[0] !== 1'b0 || busy !== 1'b1 || trc.req !== 1'b1) begin
            errors++;
            $display("FAIL start_entry: ctrl=%b busy=%b req=%b, want en=0 busy=1 req=1",
                     trace_ctrl, busy, trc.req);
        end
        for (int n = 2; n <= budget; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcyc = n;
                break;
            end
        end
        checks++;
        if (dcyc == 0) begin
            errors++;
            $display("FAIL done_timeout: no done_o within %0d cycles", budget);
        end else begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL busy_fall: busy=%b done=%b, want 0 0", busy, done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trace_en = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (trace_ctrl !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
            dout_valid !== 1'b0 || trc.req !== 1'b0 || trc.we !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ctrl=%b busy=%b done=%b valid=%b req=%b, want all 0",
                     trace_ctrl, busy, done, dout_valid, trc.req);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (trace_ctrl !== 4'b0001) begin
            errors++;
            $display("FAIL en_follow_hi: ctrl=%b want 0001", trace_ctrl);
        end
        trace_en = 1'b0;
        @(negedge clk);
        checks++;
        if (trace_ctrl !== 4'b0000) begin
            errors++;
            $display("FAIL en_follow_lo: ctrl=%b want 0000", trace_ctrl);
        end
        trace_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int dcyc, bad;
        logic [7:0] first9 [9] = '{8'h00, 8'h01, 8'h00, 8'h00,
                                   8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01};
        cpu_write(32'h0000_0100, 32'hA5A5_A5A5, 1'b1);
        cpu_write(32'h0000_0204, 32'h1234_5678, 1'b0);
        cpu_write(32'h0000_03FC, 32'hCAFE_F00D, 1'b1);
        exp_q.delete();
        add_exp(32'h0000_0100, 32'hA5A5_A5A5, 1'b1);
        add_exp(32'h0000_0204, 32'h1234_5678, 1'b0);
        add_exp(32'h0000_03FC, 32'hCAFE_F00D, 1'b1);
        add_exp(32'd0, 32'd0, 1'b0);
        got_q.delete();
        run_dump(2000, dcyc);
        checks++;
        if (dcyc != 77) begin
            errors++;
            $display("FAIL basic_latency: done after %0d cycles, want 77", dcyc);
        end
        checks++;
        if (got_q.size() != 36) begin
            errors++;
            $display("FAIL basic_count: got %0d bytes, want 36", got_q.size());
        end
        bad = 0;
        for (int i = 0; i < 9; i++)
            if (i >= got_q.size() || got_q[i] !== first9[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_first_rec: %0d of 9 leading bytes differ from 00 01 00 00 A5 A5 A5 A5 01", bad);
        end
        bad = 0;
        for (int i = 0; i < 36; i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_stream: %0d of 36 bytes differ", bad);
        end
        checks++;
        if (bad_addr != 0 || fcnt != 0 || m_addr[0] !== 32'd0 || m_data[2] !== 32'd0) begin
            errors++;
            $display("FAIL basic_flush_addr: bad_addr=%0d fcnt=%0d addr0=%h data2=%h, want 0",
                     bad_addr, fcnt, m_addr[0], m_data[2]);
        end
    endtask

    task automatic test_wrap();
        int dcyc, bad;
        for (int i = 1; i <= 6; i++)
            cpu_write(32'h1000 + 32'(i * 16), 32'hBEEF_0000 + 32'(i), 1'(i % 2));
        exp_q.delete();
        for (int i = 3; i <= 6; i++)
            add_exp(32'h1000 + 32'(i * 16), 32'hBEEF_0000 + 32'(i), 1'(i % 2));
        got_q.delete();
        run_dump(2000, dcyc);
        checks++;
        if (got_q.size() < 4 || {got_q[1], got_q[0]} !== 16'h1030) begin
            errors++;
            $display("FAIL wrap_oldest: first addr bytes=%h %h, want 30 10",
                     got_q.size() > 0 ? got_q[0] : 8'hxx, got_q.size() > 1 ? got_q[1] : 8'hxx);
        end
        bad = 0;
        for (int i = 0; i < 36; i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0 || got_q.size() != 36) begin
            errors++;
            $display("FAIL wrap_stream: %0d bytes differ, size=%0d want 36", bad, got_q.size());
        end
    endtask

    task automatic test_backpressure();
        int dcyc, bad, base;
        cpu_write(32'h0000_0100, 32'hA5A5_A5A5, 1'b1);
        cpu_write(32'h0000_0204, 32'h1234_5678, 1'b0);
        cpu_write(32'h0000_03FC, 32'hCAFE_F00D, 1'b1);
        exp_q.delete();
        add_exp(32'h0000_0100, 32'hA5A5_A5A5, 1'b1);
        add_exp(32'h0000_0204, 32'h1234_5678, 1'b0);
        add_exp(32'h0000_03FC, 32'hCAFE_F00D, 1'b1);
        add_exp(32'd0, 32'd0, 1'b0);
        got_q.delete();
        base = stall_err;
        bp = 1'b1;
        run_dump(4000, dcyc);
        bp = 1'b0;
        bad = 0;
        for (int i = 0; i < 36; i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0 || got_q.size() != 36) begin
            errors++;
            $display("FAIL bp_stream: %0d bytes differ, size=%0d want 36", bad, got_q.size());
        end
        checks++;
        if (stall_err != base) begin
            errors++;
            $display("FAIL bp_stable: %0d stalled cycles changed the byte, want 0", stall_err - base);
        end
    endtask

    task automatic test_ack_hold();
        int dcyc, reqlow, bad;
        cpu_write(32'h0000_0ABC, 32'h1122_3344, 1'b0);
        exp_q.delete();
        add_exp(32'h0000_0ABC, 32'h1122_3344, 1'b0);
        for (int i = 0; i < 3; i++) add_exp(32'd0, 32'd0, 1'b0);
        got_q.delete();
        ack_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reqlow = 0;
        dcyc = 0;
        for (int i = 0; i < 5; i++) begin
            spur = (i == 1 || i == 3);
            if (trc.req !== 1'b1) reqlow++;
            @(negedge clk);
        end
        spur = 1'b0;
        ack_en = 1'b1;
        checks++;
        if (reqlow != 0) begin
            errors++;
            $display("FAIL ack_hold_req: req low in %0d of 5 held cycles, want 0", reqlow);
        end
        for (int n = 7; n <= 2000; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcyc = n;
                break;
            end
        end
        checks++;
        if (dcyc != 82) begin
            errors++;
            $display("FAIL ack_hold_latency: done after %0d cycles, want 82", dcyc);
        end
        bad = 0;
        for (int i = 0; i < 36; i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ack_hold_stream: %0d of 36 bytes differ", bad);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_start();
        int dcyc, bad, busyhi;
        bit p1, p2;
        cpu_write(32'h0000_5550, 32'h0F0F_0F0F, 1'b1);
        cpu_write(32'h0000_6660, 32'hF0F0_F0F0, 1'b0);
        exp_q.delete();
        add_exp(32'h0000_5550, 32'h0F0F_0F0F, 1'b1);
        add_exp(32'h0000_6660, 32'hF0F0_F0F0, 1'b0);
        add_exp(32'd0, 32'd0, 1'b0);
        add_exp(32'd0, 32'd0, 1'b0);
        got_q.delete();
        p1 = 1'b0; p2 = 1'b0; dcyc = 0;
        start = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 2000; n++) begin
            start = 1'b0;
            if (done === 1'b1) begin
                dcyc = n;
                break;
            end
            if (dout_valid && !p1) begin
                start = 1'b1; p1 = 1'b1;
            end else if (trace_ctrl[1] && !p2) begin
                start = 1'b1; p2 = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (dcyc == 0 || !p1 || !p2) begin
            errors++;
            $display("FAIL busy_start_run: done_cycle=%0d send_pulse=%b flush_pulse=%b", dcyc, p1, p2);
        end
        bad = 0;
        for (int i = 0; i < 36; i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0 || got_q.size() != 36) begin
            errors++;
            $display("FAIL busy_start_stream: %0d bytes differ, size=%0d want 36", bad, got_q.size());
        end
        busyhi = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busyhi++;
        end
        checks++;
        if (busyhi != 0) begin
            errors++;
            $display("FAIL start_not_queued: busy high %0d cycles after done, want 0", busyhi);
        end
        got_q.delete();
        run_dump(2000, dcyc);
        bad = 0;
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i] !== 8'h00) bad++;
        checks++;
        if (bad != 0 || got_q.size() != 36 || fcnt != 0) begin
            errors++;
            $display("FAIL second_dump_zero: %0d nonzero bytes, size=%0d fcnt=%0d, want 0 36 0",
                     bad, got_q.size(), fcnt);
        end
    endtask

    task automatic test_reset_midop();
        cpu_write(32'h0000_7770, 32'h7777_7777, 1'b1);
        cpu_write(32'h0000_8880, 32'h8888_8888, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b0 || trc.req !== 1'b0 ||
            trace_ctrl !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: busy=%b valid=%b req=%b ctrl=%b done=%b, want all 0",
                     busy, dout_valid, trc.req, trace_ctrl, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m_addr[0] !== 32'h0000_7770 || fcnt != 0) begin
            errors++;
            $display("FAIL midop_no_flush: busy=%b addr0=%h fcnt=%0d, want 0 00007770 0",
                     busy, m_addr[0], fcnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_ack_hold();
        test_busy_start();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
